// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter (pass/LSL/LSR/ASR/ROR/RRX) with a valid/ready handshake.
// Define SHIFTER_CARRY_EN to enable carry_in/carry_out and true RRX; otherwise op 101 is ROR #1.
module shifter_pipe #(
   parameter int W      = 32,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [2:0]   op,
   input  logic [W-1:0] a,
   input  logic [7:0]   amt,
   input  logic         carry_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         carry_out
);

   localparam int LOG = $clog2(W);
   localparam logic [W-1:0] ONES = '1;
   localparam logic [7:0]   W8   = 8'(W);

   typedef logic [LOG-1:0] rot_t;

   typedef enum logic [2:0] {
      OP_PASS = 3'b000,
      OP_LSL  = 3'b001,
      OP_LSR  = 3'b010,
      OP_ASR  = 3'b011,
      OP_ROR  = 3'b100,
      OP_RRX  = 3'b101
   } op_e;

   // Every shift is a right rotate followed by overwriting the masked bits with the fill bit.
   typedef struct packed {
      logic [W-1:0] data;
      logic [W-1:0] mask;
      rot_t         rot;
      logic         fill;
      logic         carry;
   } stage_t;

   rot_t   amt_lo;
   rot_t   dn_idx;
   rot_t   neg_idx;
   logic   amt_zero;
   logic   amt_ge_w;
   logic   amt_eq_w;
   stage_t entry;

   stage_t            st    [STAGES];
   stage_t            src   [STAGES];
   stage_t            nxt   [STAGES];
   logic [STAGES-1:0] st_valid;

   assign amt_lo   = amt[LOG-1:0];
   assign dn_idx   = amt_lo - rot_t'(1);
   assign neg_idx  = rot_t'(0) - amt_lo;
   assign amt_zero = (amt == 8'd0);
   assign amt_ge_w = (amt >= W8);
   assign amt_eq_w = (amt == W8);

   // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      entry       = '0;
      entry.data  = a;
      entry.carry = carry_in;
      case (op)
         OP_LSL: begin
            if (amt_ge_w) begin
               entry.mask  = ONES;
               entry.carry = amt_eq_w ? a[0] : 1'b0;
            end else if (!amt_zero) begin
               entry.rot   = neg_idx;
               entry.mask  = ~(ONES << amt_lo);
               entry.carry = a[neg_idx];
            end
         end
         OP_LSR, OP_ASR: begin
            entry.fill = (op == OP_ASR) ? a[W-1] : 1'b0;
            if (amt_ge_w) begin
               entry.mask  = ONES;
               entry.carry = ((op == OP_ASR) || amt_eq_w) ? a[W-1] : 1'b0;
            end else if (!amt_zero) begin
               entry.rot   = amt_lo;
               entry.mask  = ~(ONES >> amt_lo);
               entry.carry = a[dn_idx];
            end
         end
         OP_ROR: begin
            if (!amt_zero) begin
               entry.rot   = amt_lo;
               entry.carry = a[dn_idx];
            end
         end
         OP_RRX: begin
            entry.rot = rot_t'(1);
`ifdef SHIFTER_CARRY_EN
            entry.mask  = {1'b1, {(W-1){1'b0}}};
            entry.fill  = carry_in;
            entry.carry = a[0];
`endif
         end
         default: begin
         end
      endcase
   end

   // Rotate level k lives in register stage (k*STAGES)/LOG; the mask is applied before the last register.
   always_comb begin
      src[0] = entry;
      for (int s = 1; s < STAGES; s++) begin
         src[s] = st[s-1];
      end
      for (int s = 0; s < STAGES; s++) begin
         nxt[s] = src[s];
         for (int k = 0; k < LOG; k++) begin
            if (((k * STAGES) / LOG == s) && src[s].rot[k]) begin
               nxt[s].data = (nxt[s].data >> (1 << k)) | (nxt[s].data << (W - (1 << k)));
            end
         end
      end
      nxt[STAGES-1].data = (nxt[STAGES-1].data & ~src[STAGES-1].mask)
                         | ({W{src[STAGES-1].fill}} & src[STAGES-1].mask);
   end

   assign out_valid = st_valid[STAGES-1];
   assign in_ready  = !out_valid || out_ready;

   // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         st_valid <= '0;
         for (int s = 0; s < STAGES; s++) begin
            st[s] <= '0;
         end
      end else if (in_ready) begin
         st_valid[0] <= in_valid;
         for (int s = 1; s < STAGES; s++) begin
            st_valid[s] <= st_valid[s-1];
         end
         for (int s = 0; s < STAGES; s++) begin
            st[s] <= nxt[s];
         end
      end
   end

   assign out_data = st[STAGES-1].data;

   logic [W+LOG:0] unused_tail;
   assign unused_tail = {st[STAGES-1].mask, st[STAGES-1].rot, st[STAGES-1].fill};

`ifdef SHIFTER_CARRY_EN
   assign carry_out = st[STAGES-1].carry;
`else
   logic unused_carry;
   assign unused_carry = st[STAGES-1].carry;
   assign carry_out    = 1'b0;
`endif

endmodule
